// File: rtl/venera_pkg.sv
`default_nettype none
// ============================================================================
// Module      : venera_pkg
// Description : Shared definitions for the Venera program loader: loader
//               state encoding, byte/instruction widths, frame length decode.
// Revision    : 1.0 - initial release
// ============================================================================
package venera_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // A length byte of zero encodes a full 256-word image.
    function automatic logic [BYTE_W:0] len_to_words(input logic [BYTE_W-1:0] len_byte);
        return (len_byte == '0) ? {1'b1, {BYTE_W{1'b0}}} : {1'b0, len_byte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/venera_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : venera_timeout_counter
// Description : Idle-gap watchdog for the loader. Counts enabled cycles since
//               the last clear and flags the cycle that completes
//               TIMEOUT_CYCLES idle cycles. TIMEOUT_CYCLES=0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module venera_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_counter
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

            logic [CW-1:0] count_q;

            // Count idle enabled cycles; saturate so the count never wraps.
            always_ff @(posedge clk or negedge areset) begin
                if (!areset) begin
                    count_q <= '0;
                end else if (clear) begin
                    count_q <= '0;
                end else if (enable && (count_q != CW'(TIMEOUT_CYCLES))) begin
                    count_q <= count_q + CW'(1);
                end
            end

            // Flags the TIMEOUT_CYCLES-th idle cycle, so the FSM leaves on
            // that cycle's edge unless a byte (clear) arrives on it.
            assign expired = enable && !clear && (count_q == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_tied
            logic unused_inputs;
            assign unused_inputs = ^{clk, areset, clear, enable};
            assign expired       = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/venera_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : venera_program_loader
// Description : Writer side of the instruction memory. Receives a framed
//               byte stream (LEN, hi/lo data byte pairs, CSUM), packs bytes
//               into words written from address 0, holds the CPU in reset
//               while loading and reports done or a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module venera_program_loader
    import venera_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = INSTR_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              im_wr,
    output logic [ADDR_W-1:0] im_address_wr,
    output logic [DATA_W-1:0] im_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = ADDR_W + 1;

    state_t              state_q;
    logic                busy_q;
    logic                im_wr_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [DATA_W-1:0]   im_din_q;
    logic                cpu_hold_q;
    logic                done_q;
    logic                error_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    word_count_q;
    logic [BYTE_W:0]     n_words_q;
    logic [BYTE_W-1:0]   hi_q;
    logic [BYTE_W-1:0]   sum_q;

    logic                accept;
    logic                expired;
    logic                tmo_clear;
    logic [ADDR_W-1:0]   addr_d;
    logic [CNT_W-1:0]    word_count_d;
    logic                last_word;

    // s_ready is the registered busy flag: ready exactly in LEN/HI/LO/CSUM.
    assign accept       = s_valid && busy_q;
    assign tmo_clear    = ((state_q == ST_IDLE) && start) || accept;
    // The address saturates at the top so a 256-word image ends at 255.
    assign addr_d       = (addr_q == {ADDR_W{1'b1}}) ? addr_q : addr_q + ADDR_W'(1);
    assign word_count_d = word_count_q + CNT_W'(1);
    assign last_word    = (word_count_d == CNT_W'(n_words_q));

    venera_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .areset  (areset),
        .clear   (tmo_clear),
        .enable  (busy_q),
        .expired (expired)
    );

    // Loader FSM with byte packing, checksum, address/word counters and all
    // registered outputs.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            im_wr_q      <= 1'b0;
            im_addr_q    <= '0;
            im_din_q     <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
            n_words_q    <= '0;
            hi_q         <= '0;
            sum_q        <= '0;
        end else begin
            im_wr_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_LEN;
                        busy_q       <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        error_q      <= 1'b0;
                        addr_q       <= '0;
                        word_count_q <= '0;
                        sum_q        <= '0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        n_words_q <= len_to_words(s_data);
                        state_q   <= ST_HI;
                    end else if (expired) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        hi_q    <= s_data;
                        sum_q   <= sum_q + s_data;
                        state_q <= ST_LO;
                    end else if (expired) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        sum_q        <= sum_q + s_data;
                        im_wr_q      <= 1'b1;
                        im_din_q     <= DATA_W'({hi_q, s_data});
                        im_addr_q    <= addr_q;
                        addr_q       <= addr_d;
                        word_count_q <= word_count_d;
                        state_q      <= last_word ? ST_CSUM : ST_HI;
                    end else if (expired) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (s_data == sum_q) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end else if (expired) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    // cpu_hold stays set until a later load succeeds.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready       = busy_q;
    assign busy          = busy_q;
    assign im_wr         = im_wr_q;
    assign im_address_wr = im_addr_q;
    assign im_din        = im_din_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_venera_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_venera_program_loader
// Description : Self-checking bench for venera_program_loader with an
//               instruction memory model, a CPU model held by cpu_hold and a
//               scoreboard of expected memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_venera_program_loader;
    import venera_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              im_wr;
    logic [ADDR_W-1:0] im_address_wr;
    logic [DATA_W-1:0] im_din;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    venera_program_loader #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .start         (start),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .im_wr         (im_wr),
        .im_address_wr (im_address_wr),
        .im_din        (im_din),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .word_count    (word_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] frame_w[$];
    logic [15:0] imem [256];
    int          wr_count   = 0;
    int          done_count = 0;
    int          cpu_pc;

    // CPU model: its reset is cpu_hold; the PC only advances when released.
    always @(posedge clk or negedge areset) begin
        if (!areset)       cpu_pc <= 0;
        else if (cpu_hold) cpu_pc <= 0;
        else               cpu_pc <= cpu_pc + 1;
    end

    // Instruction memory model and scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (im_wr) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wr", 32'(im_address_wr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(im_address_wr), 32'(e.addr));
                check_eq("wr_data", 32'(im_din), 32'(e.data));
            end
            imem[im_address_wr] = im_din;
            wr_count++;
        end
        if (done) begin
            done_count++;
            check_eq("hold_with_done", 32'(cpu_hold), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        tick(gap);
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (!s_ready && waited < 100) begin
            tick(1);
            waited++;
        end
        if (!s_ready) begin
            check_eq("byte_accept_wait", 32'(waited), 32'd0);
            s_valid = 1'b0;
            return;
        end
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Sends LEN, the words in frame_w, then CSUM (bench-computed unless forced).
    task automatic send_frame(input logic [7:0] len_b, input logic force_csum,
                              input logic [7:0] csum_val, input int max_gap,
                              input logic mid_start);
        logic [7:0]  sum;
        logic [15:0] w;
        pulse_start();
        sum = 8'h00;
        send_byte(len_b, int'($urandom_range(max_gap, 0)));
        for (int k = 0; k < frame_w.size(); k++) begin
            w = frame_w[k];
            send_byte(w[15:8], int'($urandom_range(max_gap, 0)));
            if (mid_start && k == 0) pulse_start();
            send_byte(w[7:0], int'($urandom_range(max_gap, 0)));
            exp_q.push_back({8'(k), w});
            sum = sum + w[15:8] + w[7:0];
        end
        send_byte(force_csum ? csum_val : sum, int'($urandom_range(max_gap, 0)));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int wr0, dn0, first;

        // Reset state
        areset = 1'b0;
        tick(3);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_im_wr", 32'(im_wr), 32'd0);
        check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        areset = 1'b1;
        tick(2);

        // 1: nominal three-word load
        frame_w = {16'h1234, 16'h5678, 16'h9ABC};
        pulse_start();
        check_eq("n_hold_on_start", 32'(cpu_hold), 32'd1);
        check_eq("n_busy_on_start", 32'(busy), 32'd1);
        tick(1);
        check_eq("n_cpu_held", 32'(cpu_pc), 32'd0);
        // restart through the frame task (start in LEN is ignored)
        send_frame(8'h03, 1'b0, 8'h00, 0, 1'b0);
        check_eq("n_done_pulse", 32'(done), 32'd1);
        check_eq("n_hold_released", 32'(cpu_hold), 32'd0);
        check_eq("n_busy_after", 32'(busy), 32'd0);
        tick(1);
        check_eq("n_done_one_cycle", 32'(done), 32'd0);
        check_eq("n_word_count", 32'(word_count), 32'd3);
        check_eq("n_imem0", 32'(imem[0]), 32'h1234);
        check_eq("n_imem1", 32'(imem[1]), 32'h5678);
        check_eq("n_imem2", 32'(imem[2]), 32'h9ABC);
        tick(3);
        check_eq("n_cpu_running", 32'(cpu_pc > 0), 32'd1);

        // 2: bad checksum
        dn0 = done_count;
        wr0 = wr_count;
        send_frame(8'h03, 1'b1, 8'h00, 0, 1'b0);
        check_eq("bc_error", 32'(error), 32'd1);
        check_eq("bc_hold", 32'(cpu_hold), 32'd1);
        tick(3);
        check_eq("bc_error_sticky", 32'(error), 32'd1);
        check_eq("bc_no_done", 32'(done_count - dn0), 32'd0);
        check_eq("bc_writes", 32'(wr_count - wr0), 32'd3);
        check_eq("bc_cpu_held", 32'(cpu_pc), 32'd0);

        // 3: timeout after one data byte, then a clean retry
        wr0 = wr_count;
        pulse_start();
        check_eq("to_error_cleared", 32'(error), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (error && first < 0) begin
                first = i;
                break;
            end
        end
        check_eq("to_cycles", 32'(first), 32'(TMO));
        check_eq("to_hold", 32'(cpu_hold), 32'd1);
        check_eq("to_no_wr", 32'(wr_count - wr0), 32'd0);
        tick(2);
        send_frame(8'h03, 1'b0, 8'h00, 0, 1'b0);
        check_eq("to_retry_done", 32'(done), 32'd1);
        check_eq("to_retry_error", 32'(error), 32'd0);
        tick(2);

        // 6c: byte accepted on the expiry cycle wins over the timeout
        dn0 = done_count;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h43, TMO - 1);
        send_byte(8'h21, 0);
        exp_q.push_back({8'h00, 16'h4321});
        send_byte(8'h43 + 8'h21, 0);
        check_eq("edge_error", 32'(error), 32'd0);
        tick(2);
        check_eq("edge_done", 32'(done_count - dn0), 32'd1);

        // 4: full 256-word image
        frame_w.delete();
        for (int k = 0; k < 256; k++) frame_w.push_back(16'(k));
        dn0 = done_count;
        wr0 = wr_count;
        send_frame(8'h00, 1'b0, 8'h00, 0, 1'b0);
        check_eq("full_done", 32'(done), 32'd1);
        tick(2);
        check_eq("full_writes", 32'(wr_count - wr0), 32'd256);
        check_eq("full_word_count", 32'(word_count), 32'd256);
        check_eq("full_last_addr", 32'(im_address_wr), 32'd255);
        check_eq("full_imem255", 32'(imem[255]), 32'd255);
        check_eq("full_imem0", 32'(imem[0]), 32'd0);
        check_eq("full_done_count", 32'(done_count - dn0), 32'd1);

        // 6a: start while busy is ignored
        frame_w = {16'h1234, 16'h5678, 16'h9ABC};
        dn0 = done_count;
        send_frame(8'h03, 1'b0, 8'h00, 0, 1'b1);
        tick(2);
        check_eq("sb_done", 32'(done_count - dn0), 32'd1);
        check_eq("sb_word_count", 32'(word_count), 32'd3);

        // 6b: gapped stream gives the same image
        imem[0] = 16'h0;
        imem[1] = 16'h0;
        imem[2] = 16'h0;
        dn0 = done_count;
        send_frame(8'h03, 1'b0, 8'h00, 5, 1'b0);
        tick(2);
        check_eq("gap_imem0", 32'(imem[0]), 32'h1234);
        check_eq("gap_imem1", 32'(imem[1]), 32'h5678);
        check_eq("gap_imem2", 32'(imem[2]), 32'h9ABC);
        check_eq("gap_done", 32'(done_count - dn0), 32'd1);
        check_eq("gap_error", 32'(error), 32'd0);

        // 5: reset in the middle of a load
        frame_w = {16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        dn0 = done_count;
        wr0 = wr_count;
        pulse_start();
        send_byte(8'h0A, 0);
        for (int k = 0; k < 5; k++) begin
            logic [15:0] w;
            w = frame_w[k];
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
            exp_q.push_back({8'(k), w});
        end
        tick(1);
        send_byte(8'hAA, 0);
        #2;
        areset = 1'b0;
        #1;
        check_eq("mr_s_ready", 32'(s_ready), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_cpu_hold", 32'(cpu_hold), 32'd0);
        check_eq("mr_im_wr", 32'(im_wr), 32'd0);
        check_eq("mr_error", 32'(error), 32'd0);
        check_eq("mr_word_count", 32'(word_count), 32'd0);
        check_eq("mr_addr", 32'(im_address_wr), 32'd0);
        check_eq("mr_din", 32'(im_din), 32'd0);
        tick(2);
        areset = 1'b1;
        tick(1);
        check_eq("mr_writes", 32'(wr_count - wr0), 32'd5);
        check_eq("mr_no_done", 32'(done_count - dn0), 32'd0);
        check_eq("mr_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("mr_imem4", 32'(imem[4]), 32'hA005);
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check_eq("idle_s_ready", 32'(s_ready), 32'd0);
            tick(1);
        end
        s_valid = 1'b0;
        tick(2);
        check_eq("idle_no_wr", 32'(wr_count - wr0), 32'd5);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
